// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter: FSM state encoding, port
// owner codes, latency-counter width and starvation-counter sizing.
// Latency: n/a (package). Backpressure: n/a (package).
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  // Read latency is 1..4, so the down-counter only needs to hold 0..3.
  localparam int LAT_W = 2;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W_DEF = $clog2(STARVE_LIMIT_DEF + 1);

  // Width of a counter that must be able to hold the value 'limit'.
  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating lost-arbitration counter; at_limit tells the arbiter to favour
// the starved requester. Latency: at_limit reflects inc/clr one cycle later.
// Backpressure: none, inc/clr are single-cycle strobes (clr wins over inc).
// Ports: clk, rst_n (async active-low), inc, clr, at_limit.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int CNT_W = starve_cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q >= LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU, DBG) arbiter in front of a single-ported memory; CPU has
// priority, DBG is guaranteed a grant after STARVE_LIMIT lost arbitrations.
// Latency: req->ack 2 cycles (write) / RD_LAT+1 (read); requests wait in IDLE.
// Ports: CLK, Reset (async active-low); cpu_*/dbg_* req/we/addr/wdata in,
//        rdata/ack out; MemWrite/Addr/WriteData out, MemData in; busy, owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [DATA_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              MemWrite,
  output logic [DATA_W-1:0] Addr,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemData,
  output logic              busy,
  output logic              owner
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

  arb_state_e        state_q, state_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic grant_cpu, grant_dbg;
  logic starve_at_limit;

  // Only counts arbitrations DBG actually lost to CPU while waiting.
  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (CLK),
    .rst_n    (Reset),
    .inc      (grant_cpu & dbg_req),
    .clr      (grant_dbg),
    .at_limit (starve_at_limit)
  );

  always_comb begin
    state_d     = state_q;
    mem_write_d = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_cpu   = 1'b0;
    grant_dbg   = 1'b0;

    case (state_q)
      IDLE: begin
        grant_dbg = dbg_req & (~cpu_req | starve_at_limit);
        grant_cpu = cpu_req & ~grant_dbg;
        if (grant_cpu || grant_dbg) begin
          owner_d     = grant_dbg ? OWN_DBG : OWN_CPU;
          we_d        = grant_dbg ? dbg_we : cpu_we;
          addr_d      = grant_dbg ? dbg_addr : cpu_addr;
          wdata_d     = grant_dbg ? dbg_wdata : cpu_wdata;
          // Write strobe is registered so it is high for exactly the ACCESS cycle.
          mem_write_d = grant_dbg ? dbg_we : cpu_we;
          lat_cnt_d   = LAT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q || (lat_cnt_q == '0)) begin
          if (!we_q) begin
            if (owner_q == OWN_DBG) dbg_rdata_d = MemData;
            else                    cpu_rdata_d = MemData;
          end
          cpu_ack_d = (owner_q == OWN_CPU);
          dbg_ack_d = (owner_q == OWN_DBG);
          state_d   = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      owner_q     <= OWN_CPU;
      lat_cnt_q   <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign MemWrite  = mem_write_q;
  assign Addr      = addr_q;
  assign WriteData = wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with RD_LAT=1 (combinational
// memory model) and one with RD_LAT=3 (two-stage pipelined memory model).
// Latency/backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic CLK = 1'b0;
  logic Reset;
  logic init_mem;
  always #5 CLK = ~CLK;

  // RD_LAT = 1 instance
  logic        c_req1, c_we1, c_ack1, d_req1, d_we1, d_ack1, mw1, busy1, owner1;
  logic [31:0] c_addr1, c_wdata1, c_rdata1, d_addr1, d_wdata1, d_rdata1;
  logic [31:0] addr1, wd1, md1;
  // RD_LAT = 3 instance
  logic        c_req3, c_we3, c_ack3, d_req3, d_we3, d_ack3, mw3, busy3, owner3;
  logic [31:0] c_addr3, c_wdata3, c_rdata3, d_addr3, d_wdata3, d_rdata3;
  logic [31:0] addr3, wd3, md3;

  mem_port_arbiter #(.DATA_W(32), .RD_LAT(1), .STARVE_LIMIT(4)) u_dut1 (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(c_req1), .cpu_we(c_we1), .cpu_addr(c_addr1), .cpu_wdata(c_wdata1),
    .cpu_rdata(c_rdata1), .cpu_ack(c_ack1),
    .dbg_req(d_req1), .dbg_we(d_we1), .dbg_addr(d_addr1), .dbg_wdata(d_wdata1),
    .dbg_rdata(d_rdata1), .dbg_ack(d_ack1),
    .MemWrite(mw1), .Addr(addr1), .WriteData(wd1), .MemData(md1),
    .busy(busy1), .owner(owner1)
  );

  mem_port_arbiter #(.DATA_W(32), .RD_LAT(3), .STARVE_LIMIT(4)) u_dut3 (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(c_req3), .cpu_we(c_we3), .cpu_addr(c_addr3), .cpu_wdata(c_wdata3),
    .cpu_rdata(c_rdata3), .cpu_ack(c_ack3),
    .dbg_req(d_req3), .dbg_we(d_we3), .dbg_addr(d_addr3), .dbg_wdata(d_wdata3),
    .dbg_rdata(d_rdata3), .dbg_ack(d_ack3),
    .MemWrite(mw3), .Addr(addr3), .WriteData(wd3), .MemData(md3),
    .busy(busy3), .owner(owner3)
  );

  // Memory models (word-addressed, 64 words)
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] s1_3, s2_3;
  assign md1 = mem1[addr1[7:2]];
  assign md3 = s2_3;

  always @(posedge CLK) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= 32'h0;
        mem3[i] <= 32'h0;
      end
      mem1[4]  <= 32'hDEADBEEF;
      mem3[0]  <= 32'h11111111;
      mem3[16] <= 32'hCAFEF00D;
      mem3[17] <= 32'h55555555;
    end else begin
      if (mw1) mem1[addr1[7:2]] <= wd1;
      if (mw3) mem3[addr3[7:2]] <= wd3;
    end
    s1_3 <= mem3[addr3[7:2]];
    s2_3 <= s1_3;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        exp_port;   // 0 = CPU acked, 1 = DBG acked
    logic        exp_mw;     // granted op is a write
    logic [31:0] exp_rdata;  // acked port's rdata during ack
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        got, port;
    int          lat, mw_cnt, nacks, last_ack, ack_cyc;
    logic [31:0] exp_a, exp_w;
    logic        seq[10];

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'hDEADBEEF, 2};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678,
                1'b1, 1'b1, 32'h00000000, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'h12345678, 2};
    vecs[3] = '{1'b1, 1'b1, 32'h30, 32'hAAAA5555, 1'b1, 1'b0, 32'h10, 32'h0,
                1'b0, 1'b1, 32'h12345678, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0,
                1'b1, 1'b0, 32'hAAAA5555, 2};
    vecs[5] = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                1'b0, 1'b0, 32'hDEADBEEF, 2};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,
                1'b1, 1'b0, 32'h12345678, 2};

    c_req1 = 0; c_we1 = 0; c_addr1 = 0; c_wdata1 = 0;
    d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
    c_req3 = 0; c_we3 = 0; c_addr3 = 0; c_wdata3 = 0;
    d_req3 = 0; d_we3 = 0; d_addr3 = 0; d_wdata3 = 0;
    Reset = 1'b0;
    init_mem = 1'b1;
    repeat (4) @(negedge CLK);

    // Reset state
    check("rst_memwrite",  {31'd0, mw1},    32'h0);
    check("rst_addr",      addr1,           32'h0);
    check("rst_wdata",     wd1,             32'h0);
    check("rst_cpu_ack",   {31'd0, c_ack1}, 32'h0);
    check("rst_dbg_ack",   {31'd0, d_ack1}, 32'h0);
    check("rst_cpu_rdata", c_rdata1,        32'h0);
    check("rst_dbg_rdata", d_rdata1,        32'h0);
    check("rst_busy",      {31'd0, busy1},  32'h0);
    check("rst_owner",     {31'd0, owner1}, 32'h0);
    check("rst_busy3",     {31'd0, busy3},  32'h0);
    init_mem = 1'b0;
    Reset = 1'b1;

    // Table-driven single transactions on the RD_LAT=1 instance
    for (int v = 0; v < 7; v++) begin
      @(negedge CLK);
      c_req1 = vecs[v].c_req; c_we1 = vecs[v].c_we;
      c_addr1 = vecs[v].c_addr; c_wdata1 = vecs[v].c_wdata;
      d_req1 = vecs[v].d_req; d_we1 = vecs[v].d_we;
      d_addr1 = vecs[v].d_addr; d_wdata1 = vecs[v].d_wdata;
      exp_a = vecs[v].exp_port ? vecs[v].d_addr : vecs[v].c_addr;
      exp_w = vecs[v].exp_port ? vecs[v].d_wdata : vecs[v].c_wdata;
      got = 0; lat = 0; mw_cnt = 0; port = 0;
      for (int n = 1; n <= 8 && !got; n++) begin
        @(negedge CLK);
        if (n == 1) check($sformatf("v%0d_busy", v), {31'd0, busy1}, 32'h1);
        check($sformatf("v%0d_ack_excl", v), {31'd0, c_ack1 & d_ack1}, 32'h0);
        if (mw1) begin
          mw_cnt++;
          check($sformatf("v%0d_mw_addr", v), addr1, exp_a);
          check($sformatf("v%0d_mw_wdata", v), wd1, exp_w);
        end
        if (c_ack1 || d_ack1) begin
          got = 1; lat = n; port = d_ack1;
        end
      end
      c_req1 = 0; d_req1 = 0;
      if (!got) begin
        check($sformatf("v%0d_ack_timeout", v), 32'h0, 32'h1);
      end else begin
        check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
        check($sformatf("v%0d_port", v), {31'd0, port}, {31'd0, vecs[v].exp_port});
        check($sformatf("v%0d_owner", v), {31'd0, owner1}, {31'd0, vecs[v].exp_port});
        check($sformatf("v%0d_rdata", v), port ? d_rdata1 : c_rdata1, vecs[v].exp_rdata);
        check($sformatf("v%0d_mw_cycles", v), mw_cnt, {31'd0, vecs[v].exp_mw});
      end
    end

    // Both requests held: CPU x4, DBG, CPU x4, DBG
    @(negedge CLK);
    c_req1 = 1; c_we1 = 0; c_addr1 = 32'h10;
    d_req1 = 1; d_we1 = 0; d_addr1 = 32'h20;
    nacks = 0; last_ack = 0;
    for (int n = 1; n <= 60 && nacks < 10; n++) begin
      @(negedge CLK);
      check("starve_ack_excl", {31'd0, c_ack1 & d_ack1}, 32'h0);
      if (c_ack1 || d_ack1) begin
        seq[nacks] = d_ack1;
        if (nacks > 0) check($sformatf("starve_period%0d", nacks), n - last_ack, 3);
        last_ack = n;
        nacks++;
      end
    end
    c_req1 = 0; d_req1 = 0;
    check("starve_ack_count", nacks, 10);
    for (int i = 0; i < nacks; i++)
      check($sformatf("starve_grant%0d", i), {31'd0, seq[i]}, {31'd0, (i == 4 || i == 9)});

    // RD_LAT=3 DBG read; CPU request arrives mid-ACCESS and must wait
    @(negedge CLK);
    d_req3 = 1; d_we3 = 0; d_addr3 = 32'h40;
    for (int n = 1; n <= 3; n++) begin
      @(negedge CLK);
      check($sformatf("lat3_addr_c%0d", n), addr3, 32'h40);
      check($sformatf("lat3_busy_c%0d", n), {31'd0, busy3}, 32'h1);
      check($sformatf("lat3_noack_c%0d", n), {31'd0, d_ack3}, 32'h0);
      check($sformatf("lat3_rdata_early_c%0d", n), d_rdata3, 32'h0);
      if (n == 2) begin
        c_req3 = 1; c_we3 = 0; c_addr3 = 32'h44;
        d_addr3 = 32'h7C;
      end
    end
    @(negedge CLK);
    check("lat3_dbg_ack", {31'd0, d_ack3}, 32'h1);
    check("lat3_dbg_rdata", d_rdata3, 32'hCAFEF00D);
    check("lat3_cpu_noack", {31'd0, c_ack3}, 32'h0);
    d_req3 = 0;
    ack_cyc = 0;
    for (int n = 5; n <= 14 && ack_cyc == 0; n++) begin
      @(negedge CLK);
      if (n == 5) begin
        check("lat3_idle_busy", {31'd0, busy3}, 32'h0);
        check("lat3_idle_owner", {31'd0, owner3}, 32'h1);
      end
      if (c_ack3) ack_cyc = n;
    end
    c_req3 = 0;
    check("lat3_cpu_ack_cycle", ack_cyc, 9);
    check("lat3_cpu_rdata", c_rdata3, 32'h55555555);
    check("lat3_cpu_owner", {31'd0, owner3}, 32'h0);

    // Reset during ACCESS of a CPU write
    @(negedge CLK);
    c_req1 = 1; c_we1 = 1; c_addr1 = 32'h38; c_wdata1 = 32'h0BADF00D;
    @(negedge CLK);
    check("arst_mw_before", {31'd0, mw1}, 32'h1);
    Reset = 1'b0;
    #1;
    check("arst_mw_async", {31'd0, mw1}, 32'h0);
    check("arst_busy_async", {31'd0, busy1}, 32'h0);
    c_req1 = 0; c_we1 = 0;
    @(negedge CLK);
    Reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge CLK);
      check($sformatf("arst_noack%0d", n), {31'd0, c_ack1}, 32'h0);
      check($sformatf("arst_idle%0d", n), {31'd0, busy1}, 32'h0);
    end
    check("arst_addr", addr1, 32'h0);
    check("arst_mem_untouched", mem1[14], 32'h0);

    // Fields changed during ACCESS are ignored
    @(negedge CLK);
    c_req1 = 1; c_we1 = 1; c_addr1 = 32'h3C; c_wdata1 = 32'h600DCAFE;
    @(negedge CLK);
    c_addr1 = 32'h04; c_wdata1 = 32'hFFFFFFFF; c_we1 = 0;
    #1;
    check("hold_mw", {31'd0, mw1}, 32'h1);
    check("hold_addr", addr1, 32'h3C);
    check("hold_wdata", wd1, 32'h600DCAFE);
    @(negedge CLK);
    check("hold_ack", {31'd0, c_ack1}, 32'h1);
    c_req1 = 0;
    check("hold_mem_latched", mem1[15], 32'h600DCAFE);
    check("hold_mem_other", mem1[1], 32'h0);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
